// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment display scan controller
// and the hex digit decoder.
package ssd_pkg;

    localparam int unsigned DIGIT_COUNT = 4;
    localparam int unsigned DIGIT_W     = $clog2(DIGIT_COUNT);

    // Scan FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    // Hex -> segments A..G (bit 0 = A), active-high; entry 0 at the LSB end
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Display payload captured through the load handshake
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dpMask;
    } ssdFrame_t;

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational 4-bit hex to seven-segment (A..G, active-high) decoder.
module ssd_hex_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] segPattern_c
);

    assign segPattern_c = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/ssd_scan_controller.sv
// Four-digit seven-segment scan controller with guard intervals and a
// tear-free load handshake. Build option: define SSD_LZ_BLANK_EN for leading-zero blanking.
module ssd_scan_controller
    import ssd_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 100000,
    parameter int unsigned GUARD_CYCLES = 1000,
    parameter bit          COMMON_ANODE = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        En,
    input  logic [15:0] Value,
    input  logic [3:0]  DpMask,
    input  logic        Load,
    output logic        Ready,
    output logic [3:0]  An,
    output logic [7:0]  Seg
);

    localparam int unsigned      CNT_W      = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DWELL_CYCLES - GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(DIGIT_COUNT - 1);
    localparam logic [3:0]       AN_INV     = {4{COMMON_ANODE}};
    localparam logic [7:0]       SEG_INV    = {8{COMMON_ANODE}};

    logic [1:0]         state, stateNext;
    logic [DIGIT_W-1:0] digit, digitNext;
    logic [CNT_W-1:0]   slotCnt, slotCntNext;
    ssdFrame_t          pending, pendingNext, active, activeNext;
    logic               readyNext, accept;
    logic [3:0]         anNext, nibble;
    logic [7:0]         segNext;
    logic [6:0]         hexSeg_c;
    logic               blank;

    // Next-state, counter and handshake
    always_comb begin
        stateNext   = state;
        digitNext   = digit;
        slotCntNext = slotCnt;
        pendingNext = pending;
        activeNext  = active;
        readyNext   = Ready;
        accept      = Load && Ready;

        if (!En) begin
            stateNext   = ST_IDLE;
            digitNext   = '0;
            slotCntNext = '0;
            if (accept) begin
                pendingNext = ssdFrame_t'({Value, DpMask});
                activeNext  = ssdFrame_t'({Value, DpMask});
            end else if (!Ready) begin
                activeNext = pending;
                readyNext  = 1'b1;
            end
        end else begin
            if (accept) begin
                pendingNext = ssdFrame_t'({Value, DpMask});
                readyNext   = 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    stateNext   = ST_DRIVE;
                    digitNext   = '0;
                    slotCntNext = '0;
                end
                ST_DRIVE: begin
                    slotCntNext = slotCnt + CNT_W'(1);
                    if (slotCnt == DRIVE_LAST) stateNext = ST_GUARD;
                end
                ST_GUARD: begin
                    if (slotCnt == SLOT_LAST) begin
                        stateNext   = ST_DRIVE;
                        slotCntNext = '0;
                        digitNext   = digit + DIGIT_W'(1);
                        // Frame boundary: swap in the pending frame (old contents if loaded now)
                        if (digit == DIGIT_LAST) begin
                            activeNext = pending;
                            if (!accept) readyNext = 1'b1;
                        end
                    end else begin
                        slotCntNext = slotCnt + CNT_W'(1);
                    end
                end
                default: stateNext = ST_IDLE;
            endcase
        end
    end

    assign nibble = activeNext.value[{digitNext, 2'b00} +: 4];

    ssd_hex_decoder uHexDecoder (
        .hex          (nibble),
        .segPattern_c (hexSeg_c)
    );

`ifdef SSD_LZ_BLANK_EN
    always_comb begin
        case (digitNext)
            2'd3:    blank = (activeNext.value[15:12] == 4'h0);
            2'd2:    blank = (activeNext.value[15:8] == 8'h00);
            2'd1:    blank = (activeNext.value[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // Output patterns aligned with the state being entered, polarity applied
    always_comb begin
        anNext  = AN_INV;
        segNext = SEG_INV;
        case (stateNext)
            ST_DRIVE: begin
                anNext  = (4'b0001 << digitNext) ^ AN_INV;
                segNext = {activeNext.dpMask[digitNext], blank ? 7'h00 : hexSeg_c} ^ SEG_INV;
            end
            ST_GUARD: segNext = Seg;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= ST_IDLE;
            digit   <= '0;
            slotCnt <= '0;
            pending <= '0;
            active  <= '0;
            Ready   <= 1'b1;
            An      <= AN_INV;
            Seg     <= SEG_INV;
        end else begin
            state   <= stateNext;
            digit   <= digitNext;
            slotCnt <= slotCntNext;
            pending <= pendingNext;
            active  <= activeNext;
            Ready   <= readyNext;
            An      <= anNext;
            Seg     <= segNext;
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Self-checking bench for ssd_scan_controller (DWELL=8, GUARD=2, common anode)
// against a frame-position reference model.
module tb_ssd_scan_controller;

    localparam int SLOT  = 8;
    localparam int GUARD = 2;
    localparam int FRAME = 4 * SLOT;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        En = 1'b0;
    logic [15:0] Value = '0;
    logic [3:0]  DpMask = '0;
    logic        Load = 1'b0;
    logic        Ready;
    logic [3:0]  An;
    logic [7:0]  Seg;

    int nTests = 0;
    int nFail  = 0;

    // Reference model: position within the frame (-1 = dark) plus frames
    int          mPos = -1;
    logic [19:0] mAct = '0;
    logic [19:0] mPend = '0;
    logic        mReady = 1'b1;

    ssd_scan_controller #(
        .DWELL_CYCLES (SLOT),
        .GUARD_CYCLES (GUARD),
        .COMMON_ANODE (1'b1)
    ) dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .En     (En),
        .Value  (Value),
        .DpMask (DpMask),
        .Load   (Load),
        .Ready  (Ready),
        .An     (An),
        .Seg    (Seg)
    );

    always #5 Clk = ~Clk;

    function automatic logic [6:0] hexRef(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic logic [3:0] expAn(input int pos);
        if (pos < 0 || (pos % SLOT) >= SLOT - GUARD) return 4'hF;
        return ~(4'b0001 << (pos / SLOT));
    endfunction

    // During guard the segment bus keeps the slot's own digit pattern
    function automatic logic [7:0] expSeg(input int pos, input logic [19:0] act);
        int d;
        logic [15:0] v;
        logic [6:0] p;
        if (pos < 0) return 8'hFF;
        d = pos / SLOT;
        v = act[19:4];
        p = hexRef(v[d*4 +: 4]);
`ifdef SSD_LZ_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 16'h0) p = 7'h00;
`endif
        return ~{act[d], p};
    endfunction

    // One clock edge; the model consumes the inputs as sampled at that edge
    task automatic tick();
        logic [19:0] oldPend;
        logic acc;
        @(posedge Clk);
        if (Rst) begin
            mPos = -1; mAct = '0; mPend = '0; mReady = 1'b1;
        end else if (!En) begin
            if (Load && mReady) begin
                mAct = {Value, DpMask};
                mPend = mAct;
            end else if (!mReady) begin
                mAct = mPend;
                mReady = 1'b1;
            end
            mPos = -1;
        end else begin
            oldPend = mPend;
            acc = Load && mReady;
            if (acc) begin
                mPend = {Value, DpMask};
                mReady = 1'b0;
            end
            if (mPos == FRAME - 1) begin
                mAct = oldPend;
                if (!acc) mReady = 1'b1;
            end
            mPos = (mPos < 0) ? 0 : (mPos + 1) % FRAME;
        end
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; En = 1'b0; Load = 1'b0;
        tick();
        nTests++;
        if (An !== 4'hF) begin nFail++; $display("FAIL reset_an got=%b want=1111", An); end
        nTests++;
        if (Seg !== 8'hFF) begin nFail++; $display("FAIL reset_seg got=%h want=ff", Seg); end
        nTests++;
        if (Ready !== 1'b1) begin nFail++; $display("FAIL reset_ready got=%b want=1", Ready); end
        Rst = 1'b0;
        tick();
    endtask

    task automatic test_scan_zero();
        Value = 16'h0000; DpMask = 4'h0; En = 1'b1;
        tick();
        nTests++;
        if (An !== 4'b1110 || Seg !== 8'hC0) begin
            nFail++; $display("FAIL first_drive An=%b Seg=%h want 1110/c0", An, Seg);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            nTests++;
            if ({An, Seg, Ready} !== {expAn(mPos), expSeg(mPos, mAct), mReady}) begin
                nFail++;
                $display("FAIL scan_zero pos=%0d An=%b/%b Seg=%h/%h Ready=%b/%b",
                         mPos, An, expAn(mPos), Seg, expSeg(mPos, mAct), Ready, mReady);
            end
        end
    endtask

    task automatic test_load_handshake();
        logic [7:0] want [4] = '{8'h8E, 8'h88, 8'h24, 8'hF9};
        for (int i = 0; i < 11; i++) tick();
        Value = 16'h12AF; DpMask = 4'b0100; Load = 1'b1;
        tick();
        Load = 1'b0;
        nTests++;
        if (Ready !== 1'b0) begin nFail++; $display("FAIL ready_drop got=%b want=0", Ready); end
        Value = 16'hFFFF; DpMask = 4'hF; Load = 1'b1;
        tick();
        Load = 1'b0; Value = 16'h3456;
        for (int i = 0; i < 70; i++) begin
            tick();
            nTests++;
            if ({An, Seg, Ready} !== {expAn(mPos), expSeg(mPos, mAct), mReady}) begin
                nFail++;
                $display("FAIL handshake pos=%0d An=%b/%b Seg=%h/%h Ready=%b/%b",
                         mPos, An, expAn(mPos), Seg, expSeg(mPos, mAct), Ready, mReady);
            end
            if (mAct[19:4] == 16'h12AF && mPos >= 0 && (mPos % SLOT) < SLOT - GUARD) begin
                nTests++;
                if (Seg !== want[mPos / SLOT]) begin
                    nFail++;
                    $display("FAIL seg_12af digit=%0d got=%h want=%h", mPos / SLOT, Seg, want[mPos / SLOT]);
                end
            end
        end
    endtask

    task automatic test_wrap_load();
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mReady && mPos == FRAME - 1) found = 1'b1;
            else tick();
        end
        nTests++;
        if (!found) begin nFail++; $display("FAIL wrap_wait timeout pos=%0d", mPos); end
        Value = 16'($urandom); DpMask = 4'($urandom); Load = 1'b1;
        tick();
        Load = 1'b0;
        nTests++;
        if (Ready !== 1'b0) begin nFail++; $display("FAIL wrap_ready got=%b want=0", Ready); end
        for (int i = 0; i < 70; i++) begin
            tick();
            nTests++;
            if ({An, Seg, Ready} !== {expAn(mPos), expSeg(mPos, mAct), mReady}) begin
                nFail++;
                $display("FAIL wrap_load pos=%0d An=%b/%b Seg=%h/%h Ready=%b/%b",
                         mPos, An, expAn(mPos), Seg, expSeg(mPos, mAct), Ready, mReady);
            end
        end
    endtask

    task automatic test_en_drop();
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mPos >= 2 * SLOT && mPos < 2 * SLOT + SLOT - GUARD) found = 1'b1;
            else tick();
        end
        nTests++;
        if (!found) begin nFail++; $display("FAIL endrop_wait timeout pos=%0d", mPos); end
        En = 1'b0;
        tick();
        nTests++;
        if (An !== 4'hF || Seg !== 8'hFF) begin
            nFail++; $display("FAIL en_drop An=%b Seg=%h want 1111/ff", An, Seg);
        end
        tick();
        En = 1'b1;
        tick();
        nTests++;
        if (An !== 4'b1110 || Seg !== expSeg(mPos, mAct) || Ready !== mReady) begin
            nFail++; $display("FAIL en_restart An=%b/1110 Seg=%h/%h Ready=%b/%b",
                              An, Seg, expSeg(mPos, mAct), Ready, mReady);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        for (int i = 0; i < 100 && !mReady; i++) tick();
        Value = 16'hBEEF; DpMask = 4'hA; Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mPos >= 0 && (mPos % SLOT) >= SLOT - GUARD && !mReady) found = 1'b1;
            else tick();
        end
        nTests++;
        if (!found) begin nFail++; $display("FAIL guard_wait timeout pos=%0d", mPos); end
        #2 Rst = 1'b1;
        #1;
        nTests++;
        if (An !== 4'hF || Seg !== 8'hFF || Ready !== 1'b1) begin
            nFail++; $display("FAIL async_reset An=%b Seg=%h Ready=%b want 1111/ff/1", An, Seg, Ready);
        end
        tick();
        #2 Rst = 1'b0;
        Value = 16'h7777;
        for (int i = 0; i < 34; i++) begin
            tick();
            nTests++;
            if ({An, Seg, Ready} !== {expAn(mPos), expSeg(mPos, mAct), mReady}) begin
                nFail++;
                $display("FAIL post_reset pos=%0d An=%b/%b Seg=%h/%h Ready=%b/%b",
                         mPos, An, expAn(mPos), Seg, expSeg(mPos, mAct), Ready, mReady);
            end
        end
    endtask

    task automatic test_blank();
`ifdef SSD_LZ_BLANK_EN
        logic [7:0] want [4] = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
`else
        logic [7:0] want [4] = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
`endif
        En = 1'b0;
        tick();
        Value = 16'h0050; DpMask = 4'h0; Load = 1'b1;
        tick();
        Load = 1'b0; En = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if ((mPos % SLOT) < SLOT - GUARD) begin
                nTests++;
                if (Seg !== want[mPos / SLOT]) begin
                    nFail++;
                    $display("FAIL blank_0050 digit=%0d got=%h want=%h", mPos / SLOT, Seg, want[mPos / SLOT]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            En = ($urandom_range(0, 99) != 0);
            Load = ($urandom_range(0, 3) == 0);
            Value = 16'($urandom);
            DpMask = 4'($urandom);
            tick();
            nTests++;
            if ({An, Seg, Ready} !== {expAn(mPos), expSeg(mPos, mAct), mReady}) begin
                nFail++;
                $display("FAIL random i=%0d pos=%0d An=%b/%b Seg=%h/%h Ready=%b/%b",
                         i, mPos, An, expAn(mPos), Seg, expSeg(mPos, mAct), Ready, mReady);
            end
        end
        Load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_zero();
        test_load_handshake();
        test_wrap_load();
        test_en_drop();
        test_reset_mid();
        test_blank();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/ssd_scan_controller.md
# ssd_scan_controller

Time-multiplexed scan controller for the Basys-3 four-digit seven-segment display. It accepts a 16-bit hex value plus per-digit decimal-point mask through a load handshake. It cycles the shared segment bus across the four digit anodes with anti-ghosting guard intervals. It sits between the counter/data logic and the board pins, and is the single owner of the shared segment lines.

## Interface
- DWELL_CYCLES, 100000: Clk cycles per digit slot, guard included (1 ms at 100 MHz; 4 ms frame).
- GUARD_CYCLES, 1000: cycles at the end of each slot with all anodes off; must be < DWELL_CYCLES.
- COMMON_ANODE, 1: 1 means An and Seg are active-low (Basys-3); 0 means active-high.
- Clk  in  1  system clock, 100 MHz.
- Rst  in  1  asynchronous, active-high reset.
- En  in  1  master enable; low means display dark.
- Value  in  16  hex digits; Value[3:0] is digit 0 (rightmost).
- DpMask  in  4  DP enable per digit, bit i for digit i.
- Load  in  1  request to capture Value/DpMask; accepted when Load && Ready.
- Ready  out  1  controller can accept a new value.
- An  out  4  digit anode enables; bit i drives digit i.
- Seg  out  8  Seg[0..6] drive segments A..G, Seg[7] drives DP.

## Operation
- Registers: pending {Value, DpMask}, active {Value, DpMask}, 2-bit digit index, slot counter, state.
- States:
  - IDLE (En low): An and Seg all inactive.
  - DRIVE: the current digit's anode is on and Seg carries its decoded pattern.
  - GUARD: An all inactive, Seg holds its last pattern.
- IDLE→DRIVE: when En is high; digit = 0, counter = 0.
- DRIVE→GUARD: after DWELL_CYCLES−GUARD_CYCLES cycles.
- GUARD→DRIVE: after GUARD_CYCLES cycles; digit increments mod 4.
- Any state→IDLE: En low. Digit and counter return to 0.
- Hex decode is active-high before polarity: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71. Seg[7] = DpMask[digit].
- Polarity: when COMMON_ANODE=1, An and Seg are bitwise inverted at the output registers.
- Handshake, En high:
  - Load && Ready captures Value/DpMask into pending; Ready drops the next cycle.
  - At frame boundary (GUARD of digit 3 ending, digit wraps to 0), pending copies to active and Ready returns high the same cycle.
  - The displayed frame is never torn.
- Load while Ready low is ignored; no queueing.
- Handshake, En low: Load captures directly into active (and pending); Ready stays high.
- En falling while Ready is low: pending copies to active on entering IDLE; Ready goes high.

## Timing
- Reset values:
  - An = 4'b1111, Seg = 8'hFF (COMMON_ANODE=1), or 0/0 otherwise.
  - Ready = 1, active = pending = 0, digit = 0, state IDLE.
- All outputs are registered.
- En rising at edge N: An shows digit 0 from edge N+1.
- Load accepted at edge N: Ready is low from N+1. The new value is visible on the first DRIVE of digit 0 after the next wrap. Worst-case latency is one frame (4·DWELL_CYCLES) plus 1 cycle.
- Load accepted in the wrap cycle: capture into pending wins, and pending→active also occurs that cycle with the old pending contents. Ready stays low until the following wrap.
- Slot counter width is $clog2(DWELL_CYCLES). It wraps to 0 exactly at DWELL_CYCLES−1.
- Rst mid-frame takes effect immediately (asynchronous) and clears to reset values; no partial transfer.

## Configuration
- SSD_LZ_BLANK_EN defined: leading-zero blanking.
  - Digits 3..1 that are zero, with all higher digits also zero, are blank: segments A–G off, anode still cycles normally.
  - DP still follows DpMask.
  - Digit 0 is never blanked.
- Not defined: all four digits are always shown.

## Structure
- Package ssd_pkg holds:
  - The 16-entry hex→segment constant table.
  - State enum (IDLE, DRIVE, GUARD).
  - Digit count constant 4.
- Sub-module ssd_hex_decoder: combinational 4-bit→7-bit decode, also usable by the single-digit counter design.
- The scan FSM, counter, handshake and blanking live in ssd_scan_controller.

## Test plan
Bench uses DWELL_CYCLES=8 and GUARD_CYCLES=2.
- Reset then En=1, Value=16'h0000: An sequence is 1110 ×6, 1111 ×2, 1101 ×6, … Seg=8'hC0 during DRIVE; 32-cycle frame.
- Load Value=16'h12AF, DpMask=4'b0100 mid-frame: Ready falls next cycle. After wrap:
  - digit0 Seg=8'h8E, digit1 Seg=8'h88, digit2 Seg=8'h24 (DP on), digit3 Seg=8'hF9.
  - Ready rises at the wrap.
- Second Load while Ready=0 with Value=16'hFFFF: ignored; display keeps 12AF.
- En dropped mid-DRIVE of digit 2: next cycle An=1111, Seg=FF. Re-enable restarts at digit 0.
- Rst asserted mid-GUARD with pending load: outputs return to reset values immediately, Ready=1, active=0.
- With SSD_LZ_BLANK_EN, Value=16'h0050:
  - digit 3 Seg=FF (blank), digit 2 Seg=FF (blank).
  - digit 1 Seg=8'h92 (shows 5), digit 0 Seg=8'hC0 (shows 0).
